// File: rtl/cnt_uart_pkg.sv
// Shared types and constants for the counter/FIFO/UART streamer.
// The optional header frame is enabled with CNT_UART_SYNC_HDR_EN, which uses SYNC_BYTE.
package cnt_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam int unsigned FRAME_BITS = 10;

    // Width of a counter holding 0..n-1; never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// One 8N1 frame per go: start bit, 8 data bits LSB first, stop bit, CLK_DIV clocks each.
// A go on the last stop-bit cycle chains the next frame with no idle gap.
module uart_byte_tx
    import cnt_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] data,
    output logic       line,
    output logic       done,
    output logic       busy
);

    localparam int unsigned DW = cnt_w(CLK_DIV);
    localparam int unsigned BW = cnt_w(FRAME_BITS);

    tx_state_t       state_q, state_n;
    logic [DW-1:0]   div_q, div_n;
    logic [BW-1:0]   pos_q, pos_n;
    logic [7:0]      sh_q, sh_n;
    logic            tick;

    assign tick = (div_q == DW'(CLK_DIV - 1));
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            pos_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_n;
            div_q   <= div_n;
            pos_q   <= pos_n;
            sh_q    <= sh_n;
        end
    end

    always_comb begin
        state_n = state_q;
        div_n   = tick ? '0 : div_q + DW'(1);
        pos_n   = pos_q;
        sh_n    = sh_q;
        line    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                div_n = '0;
                if (go) begin
                    sh_n    = data;
                    pos_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                line = 1'b0;
                if (tick) begin
                    pos_n   = BW'(1);
                    state_n = DATA;
                end
            end
            DATA: begin
                line = sh_q[0];
                if (tick) begin
                    sh_n  = sh_q >> 1;
                    pos_n = pos_q + BW'(1);
                    // pos counts frame bit slots; slot FRAME_BITS-2 is the last data bit
                    if (pos_q == BW'(FRAME_BITS - 2))
                        state_n = STOP;
                end
            end
            STOP: begin
                line = 1'b1;
                if (tick) begin
                    done = 1'b1;
                    if (go) begin
                        sh_n    = data;
                        pos_n   = '0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/cnt_fifo_uart_stream.sv
// Samples a free-running counter into a FIFO and streams each word as 8N1 UART bytes.
// Define CNT_UART_SYNC_HDR_EN to prefix every word with a SYNC_BYTE header frame.
module cnt_fifo_uart_stream
    import cnt_uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CLK_DIV    = 32,
    parameter int unsigned SAMPLE_DIV = 330,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          cnt_clr,
    output logic                          uart_tx,
    output logic                          tx_done,
    output logic                          word_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned NBYTES = DATA_W / 8;
`ifdef CNT_UART_SYNC_HDR_EN
    localparam int unsigned HDR_FRAMES = 1;
`else
    localparam int unsigned HDR_FRAMES = 0;
`endif
    localparam int unsigned NFRAMES = NBYTES + HDR_FRAMES;
    localparam int unsigned AW      = cnt_w(FIFO_DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned TW      = cnt_w(SAMPLE_DIV);
    localparam int unsigned IW      = cnt_w(NFRAMES);

    logic [DATA_W-1:0] cnt_q;
    logic [TW-1:0]     tmr_q;
    logic              tmr_last;
    logic              push_req;
    logic              push_ok;
    logic              pop;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [LW-1:0]     count_q;
    logic              full, empty;
    logic [15:0]       drop_q;

    logic [DATA_W-1:0] word_q;
    logic [IW-1:0]     seq_q;
    logic              seq_last;
    logic              go;
    logic [7:0]        tx_byte;
    logic              tx_busy;

    function automatic logic [7:0] frame_byte(input logic [DATA_W-1:0] w, input int unsigned f);
        int unsigned k;
        int unsigned b;
`ifdef CNT_UART_SYNC_HDR_EN
        if (f == 0)
            return SYNC_BYTE;
`endif
        k = f - HDR_FRAMES;
        b = MSB_FIRST ? (NBYTES - 1 - k) : k;
        return 8'(w >> (8 * b));
    endfunction

    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + DATA_W'(1);
    end

    assign tmr_last = (tmr_q == TW'(SAMPLE_DIV - 1));
    assign push_req = en && tmr_last;

    always_ff @(posedge clk) begin
        if (rst || !en || tmr_last)
            tmr_q <= '0;
        else
            tmr_q <= tmr_q + TW'(1);
    end

    // Fullness is judged on the registered count, so a same-cycle pop never admits a push.
    assign full    = (count_q == LW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_req && !full;
    assign pop     = !tx_busy && !empty;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_q] <= cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push_ok)
                wr_q <= wr_q + AW'(1);
            if (pop)
                rd_q <= rd_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && full && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
        end
    end

    assign seq_last = (seq_q == IW'(NFRAMES - 1));

    // First frame of a word is taken straight from the FIFO head in the pop cycle.
    always_comb begin
        go      = 1'b0;
        tx_byte = '0;
        if (pop) begin
            go      = 1'b1;
            tx_byte = frame_byte(mem[rd_q], 0);
        end else if (tx_done && !seq_last) begin
            go      = 1'b1;
            tx_byte = frame_byte(word_q, 32'(seq_q) + 32'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= '0;
        end else if (pop) begin
            word_q <= mem[rd_q];
            seq_q  <= '0;
        end else if (tx_done && !seq_last) begin
            seq_q <= seq_q + IW'(1);
        end
    end

    uart_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .data (tx_byte),
        .line (uart_tx),
        .done (tx_done),
        .busy (tx_busy)
    );

    assign word_done  = tx_done && seq_last;
    assign busy       = tx_busy;
    assign fifo_level = count_q;
    assign drop_cnt   = drop_q;

endmodule
